// File: rtl/three_bit_decoder.sv
// ============================================================================
// three_bit_decoder
// ----------------------------------------------------------------------------
// Purpose:
//    This block turns a 3-bit binary select code into a one-hot 8-bit word.
//    When enable is low, no output bit is selected. A pair of status flags
//    goes with the decode:
//    - out_valid reports whether the current decode came from an enabled
//      sample.
//    - sel_index holds the code that produced it.
//    The decode word can be registered, with one cycle of latency, or driven
//    combinationally. The status flags are always registered.
//
// Parameters:
//    ACTIVE_LOW_OUT - 0: selected bit is 1 and the others are 0.
//                     1: every decoder_out bit is inverted.
//    REGISTERED     - 1: decoder_out is registered (1 cycle latency).
//                     0: decoder_out is combinational.
//
// Ports:
//    CLK         in   sole clock; all state changes on its rising edge
//    RST         in   synchronous, active-high reset
//    binary_in   in   [2:0] select code 0..7
//    enable      in   1 = decode binary_in, 0 = select nothing
//    decoder_out out  [7:0] one-hot decode result (polarity set by ACTIVE_LOW_OUT)
//    out_valid   out  registered enable
//    sel_index   out  [2:0] registered binary_in when enabled, else 0
// ============================================================================
module three_bit_decoder #(
   parameter bit ACTIVE_LOW_OUT = 1'b0,
   parameter bit REGISTERED     = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] binary_in,
   input  logic       enable,
   output logic [7:0] decoder_out,
   output logic       out_valid,
   output logic [2:0] sel_index
);

   logic [7:0] decode_d;
   logic [7:0] activeHigh;
   logic       outValid_q;
   logic [2:0] selIndex_q;

   // Decode inside the block in active-high form.
   // Polarity is applied only at the output pin, so the reset value and the
   // stored value mean the same thing for both settings of ACTIVE_LOW_OUT.
   // Enable gates the whole word, so dropping enable wins over any
   // simultaneous change of binary_in.
   always_comb begin
      decode_d = 8'h00;
      if (enable) begin
         decode_d[binary_in] = 1'b1;
      end
   end

   // Status flags are always registered, whichever way decoder_out is built.
   // sel_index is forced to 0 for disabled samples, so that it never shows
   // a stale code while out_valid is low.
   always_ff @(posedge CLK) begin
      if (RST) begin
         outValid_q <= 1'b0;
         selIndex_q <= 3'd0;
      end else begin
         outValid_q <= enable;
         selIndex_q <= enable ? binary_in : 3'd0;
      end
   end

   generate
      if (REGISTERED) begin : gRegistered
         logic [7:0] decode_q;

         // Registered decode path.
         // The whole word is loaded in one edge, so a moving select code
         // steps straight from one bit to the next with no empty cycle.
         // Reset clears the word to "nothing selected".
         always_ff @(posedge CLK) begin
            if (RST) begin
               decode_q <= 8'h00;
            end else begin
               decode_q <= decode_d;
            end
         end

         assign activeHigh = decode_q;
      end else begin : gCombinational
         // Combinational decode path.
         // It has zero latency and no reset dependence, because only state
         // is cleared by RST.
         assign activeHigh = decode_d;
      end
   endgenerate

   // Output polarity applies to the decode word only.
   // The status flags always stay active-high.
   assign decoder_out = ACTIVE_LOW_OUT ? ~activeHigh : activeHigh;
   assign out_valid   = outValid_q;
   assign sel_index   = selIndex_q;

endmodule

// File: tb/tb_three_bit_decoder.sv
// ============================================================================
// tb_three_bit_decoder
// ----------------------------------------------------------------------------
// Purpose:
//    Drives three decoder builds from the same stimulus:
//    - dutReg:    registered, active-high (the default build)
//    - dutLow:    registered, active-low
//    - dutComb:   combinational, active-high
//    Each build is compared against a behavioural model. The model works out
//    the selected bit as 2**code and keeps the previous sample to give the
//    one-cycle latency.
// ============================================================================
module tb_three_bit_decoder;

   logic       CLK;
   logic       RST;
   logic [2:0] binaryIn;
   logic       enable;

   logic [7:0] regOut;
   logic       regValid;
   logic [2:0] regSel;

   logic [7:0] lowOut;
   logic       lowValid;
   logic [2:0] lowSel;

   logic [7:0] combOut;
   logic       combValid;
   logic [2:0] combSel;

   int checkCount;
   int errorCount;

   // Values sampled at the most recent rising edge, as seen by the model.
   logic       prevRst;
   logic       prevEn;
   logic [2:0] prevBin;

   three_bit_decoder #(.ACTIVE_LOW_OUT(1'b0), .REGISTERED(1'b1)) dutReg (
      .CLK(CLK), .RST(RST), .binary_in(binaryIn), .enable(enable),
      .decoder_out(regOut), .out_valid(regValid), .sel_index(regSel)
   );

   three_bit_decoder #(.ACTIVE_LOW_OUT(1'b1), .REGISTERED(1'b1)) dutLow (
      .CLK(CLK), .RST(RST), .binary_in(binaryIn), .enable(enable),
      .decoder_out(lowOut), .out_valid(lowValid), .sel_index(lowSel)
   );

   three_bit_decoder #(.ACTIVE_LOW_OUT(1'b0), .REGISTERED(1'b0)) dutComb (
      .CLK(CLK), .RST(RST), .binary_in(binaryIn), .enable(enable),
      .decoder_out(combOut), .out_valid(combValid), .sel_index(combSel)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference decode: nothing is selected when disabled or in reset.
   // Otherwise the selected bit has weight 2**code. Active-low builds see
   // the bitwise complement.
   function automatic logic [7:0] modelDecode(input logic rst, input logic en,
                                              input logic [2:0] code,
                                              input logic activeLow);
      int weight;
      logic [7:0] word;
      weight = (rst || !en) ? 0 : (2 ** int'(code));
      word = 8'(weight);
      return activeLow ? ~word : word;
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b, expected %b at time %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // One stimulus cycle:
   // 1. Drive the inputs just after a rising edge.
   // 2. Check the combinational build at zero latency.
   // 3. Cross the next edge and check every registered output against the
   //    sample the model recorded at that edge.
   task automatic applyStimulus(input logic rst, input logic en,
                                input logic [2:0] code);
      logic       validExp;
      logic [2:0] selExp;
      RST      = rst;
      enable   = en;
      binaryIn = code;
      #1;
      checkOutput("comb_decode", combOut, modelDecode(1'b0, en, code, 1'b0));
      @(posedge CLK);
      prevRst = rst;
      prevEn  = en;
      prevBin = code;
      #1;
      validExp = !prevRst && prevEn;
      selExp   = validExp ? prevBin : 3'd0;
      checkOutput("reg_decode", regOut, modelDecode(prevRst, prevEn, prevBin, 1'b0));
      checkOutput("reg_valid", 8'(regValid), 8'(validExp));
      checkOutput("reg_sel", 8'(regSel), 8'(selExp));
      checkOutput("low_decode", lowOut, modelDecode(prevRst, prevEn, prevBin, 1'b1));
      checkOutput("low_valid", 8'(lowValid), 8'(validExp));
      checkOutput("low_sel", 8'(lowSel), 8'(selExp));
      checkOutput("comb_valid", 8'(combValid), 8'(validExp));
      checkOutput("comb_sel", 8'(combSel), 8'(selExp));
      if (validExp) begin
         checkOutput("reg_onehot", 8'($countones(regOut)), 8'd1);
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      RST      = 1'b1;
      enable   = 1'b0;
      binaryIn = 3'd0;
      @(posedge CLK);
      #1;

      // Reset for two cycles.
      applyStimulus(1'b1, 1'b0, 3'd0);
      applyStimulus(1'b1, 1'b0, 3'd0);
      checkOutput("reset_decode", regOut, 8'h00);
      checkOutput("reset_low_decode", lowOut, 8'hFF);

      // Disabled input selects nothing.
      applyStimulus(1'b0, 1'b0, 3'd1);

      // Enabled decode, then move the selected bit.
      applyStimulus(1'b0, 1'b1, 3'd1);
      checkOutput("dir_code1", regOut, 8'b0000_0010);
      applyStimulus(1'b0, 1'b1, 3'd4);
      checkOutput("dir_code4", regOut, 8'b0001_0000);
      checkOutput("dir_sel4", 8'(regSel), 8'd4);

      // Full sweep, then drop enable.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 3'(i));
      end
      applyStimulus(1'b0, 1'b0, 3'd5);
      checkOutput("sweep_off", regOut, 8'h00);

      // Reset pulse mid-operation, then recovery.
      applyStimulus(1'b0, 1'b1, 3'd7);
      applyStimulus(1'b1, 1'b1, 3'd7);
      checkOutput("rst_pulse", regOut, 8'h00);
      applyStimulus(1'b0, 1'b1, 3'd7);
      checkOutput("rst_recover", regOut, 8'b1000_0000);

      // Active-low build.
      applyStimulus(1'b0, 1'b1, 3'd2);
      checkOutput("low_code2", lowOut, 8'b1111_1011);
      applyStimulus(1'b0, 1'b0, 3'd2);
      checkOutput("low_off", lowOut, 8'b1111_1111);

      // Random traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
